// File: rtl/cache_ctrl.sv
// Write-back, write-allocate, fully associative cache controller with round-robin replacement.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module cache_ctrl #(
    parameter int LINES   = 4,
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 3,
    parameter int MEM_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_hit,
    output logic [ADDR_W-1:0] mem_endereco,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_out,
    output logic [ADDR_W-1:0] mem_enderecoWB,
    output logic [DATA_W-1:0] mem_dadoWB,
    output logic              mem_WB,
    output logic [2:0]        state_dbg
`ifdef CACHE_STATS_EN
    ,
    output logic [7:0]        hit_count,
    output logic [7:0]        miss_count
`endif
);
    localparam int IW = (LINES > 1) ? $clog2(LINES) : 1;

    typedef enum logic [2:0] {IDLE, WB, FILL, FILL_WAIT, RESP} state_t;

    state_t              state;
    logic [LINES-1:0]    valid;
    logic [LINES-1:0]    dirty;
    logic [ADDR_W-1:0]   tag  [LINES];
    logic [DATA_W-1:0]   data [LINES];
    logic [IW-1:0]       rr;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [IW-1:0]       victim_q;
    logic                use_rr_q;
    logic [2:0]          wait_cnt;

    logic                hit;
    logic [IW-1:0]       hit_idx;
    logic                has_inv;
    logic [IW-1:0]       inv_idx;
    logic [IW-1:0]       victim;

    logic                ins_en;
    logic [IW-1:0]       ins_idx;
    logic [ADDR_W-1:0]   ins_tag;
    logic [DATA_W-1:0]   ins_data;
    logic                ins_dirty;
    logic                ins_adv;

    assign ready     = (state == IDLE);
    assign state_dbg = state;

    // Descending scan so the lowest-index invalid line wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        has_inv = 1'b0;
        inv_idx = '0;
        for (int i = LINES - 1; i >= 0; i--) begin
            if (valid[i] && tag[i] == req_addr) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
            if (!valid[i]) begin
                has_inv = 1'b1;
                inv_idx = IW'(i);
            end
        end
    end

    assign victim = has_inv ? inv_idx : rr;

    // A line is installed from one of three places: clean write miss, write after WB, or fill return.
    always_comb begin
        ins_en    = 1'b0;
        ins_idx   = victim_q;
        ins_tag   = addr_q;
        ins_data  = wdata_q;
        ins_dirty = 1'b1;
        ins_adv   = use_rr_q;
        case (state)
            IDLE: begin
                if (req_valid && !hit && !dirty[victim] && req_we) begin
                    ins_en   = 1'b1;
                    ins_idx  = victim;
                    ins_tag  = req_addr;
                    ins_data = req_wdata;
                    ins_adv  = !has_inv;
                end
            end
            WB:        ins_en = we_q;
            FILL_WAIT: begin
                if (wait_cnt == 3'd0) begin
                    ins_en    = 1'b1;
                    ins_data  = mem_out;
                    ins_dirty = 1'b0;
                end
            end
            default: ins_en = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            valid          <= '0;
            dirty          <= '0;
            rr             <= '0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            victim_q       <= '0;
            use_rr_q       <= 1'b0;
            wait_cnt       <= '0;
            resp_valid     <= 1'b0;
            resp_hit       <= 1'b0;
            resp_rdata     <= '0;
            mem_read       <= 1'b0;
            mem_endereco   <= '0;
            mem_WB         <= 1'b0;
            mem_enderecoWB <= '0;
            mem_dadoWB     <= '0;
`ifdef CACHE_STATS_EN
            hit_count      <= '0;
            miss_count     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        if (hit) begin
                            if (req_we) begin
                                data[hit_idx]  <= req_wdata;
                                dirty[hit_idx] <= 1'b1;
                            end
                            resp_rdata <= req_we ? req_wdata : data[hit_idx];
                            resp_valid <= 1'b1;
                            resp_hit   <= 1'b1;
                            state      <= RESP;
                        end else begin
                            victim_q <= victim;
                            use_rr_q <= !has_inv;
                            if (dirty[victim]) begin
                                mem_WB         <= 1'b1;
                                mem_enderecoWB <= tag[victim];
                                mem_dadoWB     <= data[victim];
                                state          <= WB;
                            end else if (req_we) begin
                                resp_rdata <= req_wdata;
                                resp_valid <= 1'b1;
                                resp_hit   <= 1'b0;
                                state      <= RESP;
                            end else begin
                                mem_read     <= 1'b1;
                                mem_endereco <= req_addr;
                                state        <= FILL;
                            end
                        end
                    end
                end
                WB: begin
                    mem_WB <= 1'b0;
                    if (we_q) begin
                        resp_rdata <= wdata_q;
                        resp_valid <= 1'b1;
                        resp_hit   <= 1'b0;
                        state      <= RESP;
                    end else begin
                        mem_read     <= 1'b1;
                        mem_endereco <= addr_q;
                        state        <= FILL;
                    end
                end
                FILL: begin
                    mem_read <= 1'b0;
                    wait_cnt <= 3'(MEM_LAT - 1);
                    state    <= FILL_WAIT;
                end
                FILL_WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        resp_rdata <= mem_out;
                        resp_valid <= 1'b1;
                        resp_hit   <= 1'b0;
                        state      <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                RESP: begin
`ifdef CACHE_STATS_EN
                    if (resp_hit) begin
                        if (hit_count != 8'hFF) hit_count <= hit_count + 8'd1;
                    end else begin
                        if (miss_count != 8'hFF) miss_count <= miss_count + 8'd1;
                    end
`endif
                    resp_valid <= 1'b0;
                    resp_hit   <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (ins_en) begin
                valid[ins_idx] <= 1'b1;
                dirty[ins_idx] <= ins_dirty;
                tag[ins_idx]   <= ins_tag;
                data[ins_idx]  <= ins_data;
                if (ins_adv) rr <= rr + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cache_ctrl.sv
// Randomized self-checking bench for cache_ctrl: a line-level cache model plus a backing memory
// with MEM_LAT fill latency; covers CACHE_STATS_EN counters when that macro is defined.
module tb_cache_ctrl;
  localparam int LINES   = 4;
  localparam int ADDR_W  = 3;
  localparam int DATA_W  = 3;
  localparam int MEM_LAT = 1;
  localparam int DEPTH   = 1 << ADDR_W;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              ready;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_hit;
  logic [ADDR_W-1:0] mem_endereco;
  logic              mem_read;
  logic [DATA_W-1:0] mem_out = '0;
  logic [ADDR_W-1:0] mem_enderecoWB;
  logic [DATA_W-1:0] mem_dadoWB;
  logic              mem_WB;
  logic [2:0]        state_dbg;
`ifdef CACHE_STATS_EN
  logic [7:0]        hit_count;
  logic [7:0]        miss_count;
`endif

  cache_ctrl #(.LINES(LINES), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .ready(ready), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_hit(resp_hit), .mem_endereco(mem_endereco),
    .mem_read(mem_read), .mem_out(mem_out), .mem_enderecoWB(mem_enderecoWB),
    .mem_dadoWB(mem_dadoWB), .mem_WB(mem_WB), .state_dbg(state_dbg)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  // clock / reset
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // backing memory seen by the DUT, and the model's own copy of it
  logic [DATA_W-1:0] mem     [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  int                fill_cd = 0;
  logic [ADDR_W-1:0] fill_addr = '0;

  // Fill data is valid only in the cycle MEM_LAT after the mem_read pulse; garbage otherwise.
  always @(negedge clock) begin
    if (mem_WB) mem[mem_enderecoWB] = mem_dadoWB;
    if (mem_read) begin
      fill_cd   = MEM_LAT;
      fill_addr = mem_endereco;
      mem_out   = DATA_W'($urandom);
    end else if (fill_cd > 0) begin
      fill_cd--;
      mem_out = (fill_cd == 0) ? mem[fill_addr] : DATA_W'($urandom);
    end else begin
      mem_out = DATA_W'($urandom);
    end
  end

  // reference cache model
  bit                m_valid [LINES];
  bit                m_dirty [LINES];
  logic [ADDR_W-1:0] m_tag   [LINES];
  logic [DATA_W-1:0] m_data  [LINES];
  int                m_rr;
  logic [DATA_W-1:0] exp_q[$];

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
      m_data[i]  = '0;
    end
    m_rr = 0;
    exp_q.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_outs"}, {resp_valid, resp_hit, mem_read, mem_WB, resp_rdata,
                           mem_endereco, mem_enderecoWB, mem_dadoWB}, 0);
    check({tag, "_ready"}, ready, 1);
  endtask

  task automatic do_reset();
    req_valid = 1'b0;
    reset     = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check_idle_outputs("reset");
    model_clear();
  endtask

  // driver: issue one request from a negedge with ready high, follow it to its response
  task automatic do_req(input bit we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    int h, v, lat, e_fill_k, wb_n, wb_k, fill_n, fill_k, resp_k;
    bit use_rr, e_hit, e_wb, e_fill, got_resp, got_hit;
    logic [ADDR_W-1:0] e_wb_a, wb_a, fill_a;
    logic [DATA_W-1:0] e_wb_d, wb_d, got_rdata, exp_rd;

    h = -1;
    e_wb = 0; e_fill = 0; e_fill_k = 0; e_wb_a = '0; e_wb_d = '0;
    for (int i = 0; i < LINES; i++)
      if (m_valid[i] && m_tag[i] == addr) h = i;
    if (h >= 0) begin
      e_hit = 1;
      lat   = 1;
      if (we) begin
        m_data[h]  = wdata;
        m_dirty[h] = 1'b1;
        exp_q.push_back(wdata);
      end else begin
        exp_q.push_back(m_data[h]);
      end
    end else begin
      e_hit = 0;
      v = -1;
      for (int i = LINES - 1; i >= 0; i--)
        if (!m_valid[i]) v = i;
      use_rr = (v < 0);
      if (use_rr) v = m_rr;
      e_wb = m_dirty[v];
      if (e_wb) begin
        e_wb_a = m_tag[v];
        e_wb_d = m_data[v];
        ref_mem[m_tag[v]] = m_data[v];
      end
      if (we) begin
        m_data[v]  = wdata;
        m_dirty[v] = 1'b1;
        lat = e_wb ? 2 : 1;
      end else begin
        m_data[v]  = ref_mem[addr];
        m_dirty[v] = 1'b0;
        e_fill   = 1;
        e_fill_k = e_wb ? 2 : 1;
        lat      = e_fill_k + 1 + MEM_LAT;
      end
      exp_q.push_back(m_data[v]);
      m_valid[v] = 1'b1;
      m_tag[v]   = addr;
      if (use_rr) m_rr = (m_rr + 1) % LINES;
    end

    check("ready_before_req", ready, 1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;

    got_resp = 0; got_hit = 0; got_rdata = '0; resp_k = 0;
    wb_n = 0; wb_k = 0; wb_a = '0; wb_d = '0;
    fill_n = 0; fill_k = 0; fill_a = '0;
    for (int k = 1; k <= 20 && !got_resp; k++) begin
      @(negedge clock);
      // requests presented while busy must be ignored
      req_valid = 1'($urandom_range(0, 1));
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = ADDR_W'($urandom);
      req_wdata = DATA_W'($urandom);
      if (mem_WB && mem_read) check("wb_fill_overlap", 1, 0);
      if (mem_WB) begin
        wb_n++; wb_k = k; wb_a = mem_enderecoWB; wb_d = mem_dadoWB;
      end
      if (mem_read) begin
        fill_n++; fill_k = k; fill_a = mem_endereco;
      end
      if (resp_valid) begin
        got_resp  = 1;
        resp_k    = k;
        got_hit   = resp_hit;
        got_rdata = resp_rdata;
        req_valid = 1'b0;
        if (e_wb) check("wb_addr_held", mem_enderecoWB, e_wb_a);
      end
    end
    req_valid = 1'b0;

    exp_rd = exp_q.pop_front();
    check("resp_seen", got_resp, 1);
    if (got_resp) begin
      check("resp_latency", resp_k, lat);
      check("resp_hit", got_hit, e_hit);
      check("resp_rdata", got_rdata, exp_rd);
    end
    check("wb_count", wb_n, e_wb);
    if (e_wb) begin
      check("wb_cycle", wb_k, 1);
      check("wb_addr", wb_a, e_wb_a);
      check("wb_data", wb_d, e_wb_d);
    end
    check("fill_count", fill_n, e_fill);
    if (e_fill) begin
      check("fill_cycle", fill_k, e_fill_k);
      check("fill_addr", fill_a, addr);
    end

    @(negedge clock);
    check("resp_one_cycle", resp_valid, 0);
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++) begin
      mem[a]     = DATA_W'($urandom);
      ref_mem[a] = mem[a];
    end
    mem[3] = 3'b010; ref_mem[3] = 3'b010;
    mem[1] = 3'b001; ref_mem[1] = 3'b001;
    mem[2] = 3'b100; ref_mem[2] = 3'b100;

    // read miss then read hit
    do_reset();
    do_req(1'b0, 3'd3, 3'd0);
    do_req(1'b0, 3'd3, 3'd0);

    // write miss then read hit
    do_reset();
    do_req(1'b1, 3'd2, 3'b111);
    do_req(1'b0, 3'd2, 3'd0);

    // dirty eviction by round robin, then clean eviction returning written-back data
    do_reset();
    do_req(1'b1, 3'd2, 3'b111);
    do_req(1'b0, 3'd3, 3'd0);
    do_req(1'b0, 3'd4, 3'd0);
    do_req(1'b0, 3'd5, 3'd0);
    do_req(1'b0, 3'd1, 3'd0);
    do_req(1'b0, 3'd2, 3'd0);
    check("wb_landed_in_mem", mem[2], 3'b111);

    // reset during FILL_WAIT discards dirty data and the pending response
    do_reset();
    do_req(1'b1, 3'd6, 3'd5);
    check("rm_ready", ready, 1);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd7; req_wdata = '0;
    @(negedge clock);
    req_valid = 1'b0;
    check("rm_fill_pulse", mem_read, 1);
    @(negedge clock);
    check("rm_no_resp_wait", resp_valid, 0);
    reset = 1'b1;
    @(negedge clock);
    check_idle_outputs("rm_after");
    reset = 1'b0;
    model_clear();
    do_req(1'b0, 3'd6, 3'd0);

    // randomized traffic
    do_reset();
    repeat (300) begin
      repeat ($urandom_range(0, 2)) @(negedge clock);
      do_req(1'($urandom_range(0, 1)), ADDR_W'($urandom), DATA_W'($urandom));
    end

`ifdef CACHE_STATS_EN
    do_reset();
    check("stats_reset_hits", hit_count, 0);
    check("stats_reset_miss", miss_count, 0);
    do_req(1'b0, 3'd3, 3'd0);
    repeat (300) do_req(1'b0, 3'd3, 3'd0);
    check("stats_hits_sat", hit_count, 255);
    check("stats_miss", miss_count, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
